// File: rtl/parking_gate_ctrl.sv
// Barrier gate controller for the single shared lane of the parking lot.
// Arbitrates entry/exit requests against the occupancy count, opens the
// gate for one car at a time, confirms passage through the lane sensor and
// closes the gate again. Freezes in LOCKED when the counter reports an error.
module parking_gate_ctrl #(
  parameter logic [3:0]  CAPACITY     = 4'd12,
  parameter logic [25:0] WAIT_CYCLES  = 26'd50_000_000,
  parameter logic [25:0] CLOSE_CYCLES = 26'd25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       entry_req,
  input  logic       exit_req,
  input  logic       lane_busy,
  input  logic [3:0] conteo,
  input  logic       hubo_error,
  output logic       gate_open,
  output logic       lane_dir,
  output logic       served_entry,
  output logic       served_exit,
  output logic       denied,
  output logic       locked
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_CAR = 3'd1,
    PASSING  = 3'd2,
    CLOSING  = 3'd3,
    LOCKED   = 3'd4
  } state_t;

  localparam logic DIR_ENTRY = 1'b0;
  localparam logic DIR_EXIT  = 1'b1;

  // Terminal counts: the timer starts at 0, so the last cycle is N-1.
  localparam logic [25:0] WAIT_LAST  = WAIT_CYCLES - 26'd1;
  localparam logic [25:0] CLOSE_LAST = CLOSE_CYCLES - 26'd1;

  state_t      state;
  logic [25:0] timer;
  logic [25:0] deny_cnt;
  logic        last_served;

  logic        ent_ok;
  logic        ext_ok;
  logic        grant_valid;
  logic        grant_dir;
  logic        deny_cond;

  // Saturating increment: the timers hold at all-ones instead of wrapping.
  function automatic logic [25:0] sat_inc(input logic [25:0] v);
    return (v == '1) ? v : v + 26'd1;
  endfunction

  // Request qualification and round-robin arbitration for the shared lane.
  always_comb begin
    ent_ok      = entry_req & (conteo < CAPACITY);
    ext_ok      = exit_req & (conteo != 4'd0);
    grant_valid = ent_ok | ext_ok;
    // On a tie the side not served last wins; otherwise the only qualified side.
    if (ent_ok && ext_ok) begin
      grant_dir = ~last_served;
    end else begin
      grant_dir = ext_ok;
    end
    // A refusal only happens when nothing can be served at all.
    deny_cond = (entry_req | exit_req) & ~grant_valid;
  end

  // Gate sequencing FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      gate_open    <= 1'b0;
      lane_dir     <= DIR_ENTRY;
      served_entry <= 1'b0;
      served_exit  <= 1'b0;
      denied       <= 1'b0;
      locked       <= 1'b0;
      timer        <= '0;
      deny_cnt     <= '0;
      last_served  <= DIR_EXIT;
    end else begin
      // Pulse outputs default low; the branches below raise them for one cycle.
      served_entry <= 1'b0;
      served_exit  <= 1'b0;
      denied       <= 1'b0;

      if (hubo_error) begin
        // A counter error freezes the controller from any state.
        state     <= LOCKED;
        gate_open <= 1'b0;
        locked    <= 1'b1;
        deny_cnt  <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (grant_valid) begin
              lane_dir  <= grant_dir;
              timer     <= '0;
              deny_cnt  <= '0;
              gate_open <= 1'b1;
              state     <= WAIT_CAR;
            end else if (deny_cond) begin
              // Refuse once immediately, then once per WAIT_CYCLES while held.
              if (deny_cnt == 26'd0) begin
                denied <= 1'b1;
              end
              if (deny_cnt >= WAIT_LAST) begin
                deny_cnt <= '0;
              end else begin
                deny_cnt <= deny_cnt + 26'd1;
              end
            end else begin
              deny_cnt <= '0;
            end
          end

          WAIT_CAR: begin
            if (lane_busy) begin
              state <= PASSING;
            end else if (timer >= WAIT_LAST) begin
              // Driver never showed up: close without a served pulse.
              gate_open <= 1'b0;
              state     <= IDLE;
            end else begin
              timer <= sat_inc(timer);
            end
          end

          PASSING: begin
            if (!lane_busy) begin
              served_entry <= (lane_dir == DIR_ENTRY);
              served_exit  <= (lane_dir == DIR_EXIT);
              timer        <= '0;
              state        <= CLOSING;
            end
          end

          CLOSING: begin
            if (lane_busy) begin
              // A following car entered under the open gate; wait for it too.
              state <= PASSING;
            end else if (timer >= CLOSE_LAST) begin
              gate_open   <= 1'b0;
              last_served <= lane_dir;
              state       <= IDLE;
            end else begin
              timer <= sat_inc(timer);
            end
          end

          LOCKED: begin
            gate_open <= 1'b0;
            locked    <= 1'b1;
          end

          default: begin
            gate_open <= 1'b0;
            state     <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed-plus-random bench for parking_gate_ctrl with a transaction-level
// reference model of the arbitration rules and the gate timing.
module tb_parking_gate_ctrl;

  localparam int CAP_I  = 12;
  localparam int WAITC  = 8;
  localparam int CLOSEC = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       entry_req;
  logic       exit_req;
  logic       lane_busy;
  logic [3:0] conteo;
  logic       hubo_error;
  logic       gate_open;
  logic       lane_dir;
  logic       served_entry;
  logic       served_exit;
  logic       denied;
  logic       locked;

  int total = 0;
  int bad   = 0;
  bit model_last;  // 1 = exit served last

  parking_gate_ctrl #(
    .CAPACITY     (4'd12),
    .WAIT_CYCLES  (26'd8),
    .CLOSE_CYCLES (26'd4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .entry_req    (entry_req),
    .exit_req     (exit_req),
    .lane_busy    (lane_busy),
    .conteo       (conteo),
    .hubo_error   (hubo_error),
    .gate_open    (gate_open),
    .lane_dir     (lane_dir),
    .served_entry (served_entry),
    .served_exit  (served_exit),
    .denied       (denied),
    .locked       (locked)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input bit g, input bit se, input bit sx,
                         input bit den, input bit lk);
    chk({tag, ".gate_open"}, gate_open, g);
    chk({tag, ".served_entry"}, served_entry, se);
    chk({tag, ".served_exit"}, served_exit, sx);
    chk({tag, ".denied"}, denied, den);
    chk({tag, ".locked"}, locked, lk);
  endtask

  // Reference decision for a fresh request seen in IDLE:
  // 0 = serve entry, 1 = serve exit, 2 = refuse, 3 = nothing requested.
  function automatic int predict(bit er, bit xr, int cnt, bit last);
    bit eok;
    bit xok;
    eok = er && (cnt < CAP_I);
    xok = xr && (cnt != 0);
    if (eok && xok) return last ? 0 : 1;
    if (eok) return 0;
    if (xok) return 1;
    if (er || xr) return 2;
    return 3;
  endfunction

  // One idle cycle with no requests, then present a request and check the decision.
  task automatic request(input bit er, input bit xr, input logic [3:0] cnt, output int side);
    entry_req = 1'b0;
    exit_req  = 1'b0;
    conteo    = cnt;
    step();
    chk("idle_pre.gate_open", gate_open, 0);
    entry_req = er;
    exit_req  = xr;
    side = predict(er, xr, int'(cnt), model_last);
    step();
    if (side < 2) begin
      chk("req.gate_open", gate_open, 1);
      chk("req.lane_dir", lane_dir, side);
      chk("req.denied", denied, 0);
    end else begin
      chk("req.gate_open", gate_open, 0);
      chk("req.denied", denied, (side == 2) ? 1 : 0);
    end
  endtask

  // Car arrives after 'delay' cycles, occupies the lane 'busy' cycles, then leaves.
  task automatic carry_car(input int dir, input int delay, input int busy);
    lane_busy = 1'b0;
    for (int i = 0; i < delay; i++) begin
      step();
      chk_out("wait", 1, 0, 0, 0, 0);
    end
    lane_busy = 1'b1;
    for (int i = 0; i < busy; i++) begin
      step();
      chk_out("pass", 1, 0, 0, 0, 0);
    end
    lane_busy = 1'b0;
    step();
    chk_out("served", 1, dir == 0, dir == 1, 0, 0);
  endtask

  // After the served pulse the gate stays open CLOSE cycles, then drops.
  task automatic close_out(input int dir);
    for (int i = 0; i < CLOSEC - 1; i++) begin
      step();
      chk_out("closing", 1, 0, 0, 0, 0);
    end
    step();
    chk_out("closed", 0, 0, 0, 0, 0);
    model_last = (dir == 1);
  endtask

  // Gate opened but no car comes: open for exactly WAIT cycles in total.
  task automatic timeout_path();
    entry_req = 1'b0;
    exit_req  = 1'b0;
    lane_busy = 1'b0;
    for (int i = 0; i < WAITC - 1; i++) begin
      step();
      chk_out("timeout_wait", 1, 0, 0, 0, 0);
    end
    step();
    chk_out("timeout_done", 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_last = 1'b1;
  endtask

  initial begin
    int side;
    int n;
    reset      = 1'b1;
    entry_req  = 1'b0;
    exit_req   = 1'b0;
    lane_busy  = 1'b0;
    conteo     = 4'd0;
    hubo_error = 1'b0;
    model_last = 1'b1;
    step();
    step();
    chk_out("reset", 0, 0, 0, 0, 0);
    chk("reset.lane_dir", lane_dir, 0);
    reset = 1'b0;

    // Basic entry
    request(1'b1, 1'b0, 4'($urandom_range(0, 11)), side);
    entry_req = 1'b0;
    carry_car(side, $urandom_range(0, 6), 3);
    close_out(side);

    // Basic exit
    request(1'b0, 1'b1, 4'($urandom_range(1, 12)), side);
    exit_req = 1'b0;
    carry_car(side, $urandom_range(0, 6), $urandom_range(1, 4));
    close_out(side);

    // Full lot: held entry request refused once per WAIT cycles
    request(1'b1, 1'b0, 4'd12, side);
    chk_out("full0", 0, 0, 0, 1, 0);
    for (int i = 1; i < 20; i++) begin
      step();
      chk_out("full", 0, 0, 0, (i % WAITC) == 0, 0);
    end

    // Empty lot: exit refused
    request(1'b0, 1'b1, 4'd0, side);
    chk("empty.denied", denied, 1);

    // Full lot with exit also requesting: exit is served, no refusal
    request(1'b1, 1'b1, 4'd12, side);
    entry_req = 1'b0;
    exit_req  = 1'b0;
    carry_car(side, 1, 2);
    close_out(side);

    // Tie arbitration from a fresh reset: entry, exit, entry
    do_reset();
    request(1'b1, 1'b1, 4'd5, side);
    chk("tie1.lane_dir", lane_dir, 0);
    carry_car(side, $urandom_range(0, 6), $urandom_range(1, 3));
    close_out(side);
    for (int k = 0; k < 2; k++) begin
      side = predict(1'b1, 1'b1, 5, model_last);
      step();
      chk("tie.gate_open", gate_open, 1);
      chk("tie.lane_dir", lane_dir, side);
      carry_car(side, $urandom_range(0, 6), $urandom_range(1, 3));
      close_out(side);
    end
    chk("tie3.lane_dir", lane_dir, 0);

    // Timeout on an exit request
    request(1'b0, 1'b1, 4'd2, side);
    timeout_path();

    // Tailgate: second car enters 2 cycles into CLOSING
    request(1'b1, 1'b0, 4'($urandom_range(0, 11)), side);
    entry_req = 1'b0;
    carry_car(side, $urandom_range(0, 6), $urandom_range(1, 3));
    step();
    chk_out("tail_close1", 1, 0, 0, 0, 0);
    lane_busy = 1'b1;
    step();
    chk_out("tail_pass", 1, 0, 0, 0, 0);
    n = $urandom_range(1, 3);
    for (int i = 0; i < n; i++) begin
      step();
      chk_out("tail_hold", 1, 0, 0, 0, 0);
    end
    lane_busy = 1'b0;
    step();
    chk_out("tail_served", 1, side == 0, side == 1, 0, 0);
    close_out(side);

    // Randomized transactions against the model
    for (int it = 0; it < 12; it++) begin
      request(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              4'($urandom_range(0, 15)), side);
      entry_req = 1'b0;
      exit_req  = 1'b0;
      if (side < 2) begin
        if ($urandom_range(0, 3) == 0) begin
          timeout_path();
        end else begin
          carry_car(side, $urandom_range(0, 6), $urandom_range(1, 4));
          close_out(side);
        end
      end
    end

    // Reset mid-operation: no served pulse for the car in the lane
    request(1'b0, 1'b1, 4'($urandom_range(1, 12)), side);
    exit_req  = 1'b0;
    lane_busy = 1'b1;
    step();
    chk_out("mid_pass", 1, 0, 0, 0, 0);
    reset     = 1'b1;
    lane_busy = 1'b0;
    step();
    chk_out("mid_reset", 0, 0, 0, 0, 0);
    reset = 1'b0;
    model_last = 1'b1;
    step();
    chk_out("mid_after", 0, 0, 0, 0, 0);

    // Error during PASSING locks the controller
    request(1'b1, 1'b0, 4'($urandom_range(0, 11)), side);
    lane_busy = 1'b1;
    step();
    chk_out("err_pass", 1, 0, 0, 0, 0);
    hubo_error = 1'b1;
    step();
    chk_out("err_locked", 0, 0, 0, 0, 1);
    hubo_error = 1'b0;
    lane_busy  = 1'b0;
    exit_req   = 1'b1;
    conteo     = 4'd4;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_out("err_hold", 0, 0, 0, 0, 1);
    end
    entry_req = 1'b0;
    exit_req  = 1'b0;
    do_reset();
    chk_out("err_reset", 0, 0, 0, 0, 0);
    chk("err_reset.lane_dir", lane_dir, 0);

    // Error and reset on the same edge: reset wins
    hubo_error = 1'b1;
    reset      = 1'b1;
    step();
    chk_out("both", 0, 0, 0, 0, 0);
    hubo_error = 1'b0;
    reset      = 1'b0;
    step();
    chk_out("both_after", 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/parking_gate_ctrl.md
# parking_gate_ctrl

Controller for the single-lane barrier gate of the parking meter. It arbitrates entry and exit requests for the one shared lane and opens the gate for one car at a time. It watches the debounced lane sensor to confirm the car passed, then closes the gate. It consumes the occupancy count and error flag produced by the parking counter and refuses entry when the lot is full and exit when it is empty.

## Interface
Parameters:
- CAPACITY, 4'd12: maximum occupancy; entry is refused when conteo >= CAPACITY.
- WAIT_CYCLES, 26'd50_000_000: cycles the gate stays open waiting for a car before it gives up.
- CLOSE_CYCLES, 26'd25_000_000: cycles the gate stays open after the car clears the lane.

Ports:
- clk  in  1  system clock; the block has one clock.
- reset  in  1  synchronous, active-high reset.
- entry_req  in  1  debounced level, driver at the entry side wants in.
- exit_req  in  1  debounced level, driver at the exit side wants out.
- lane_busy  in  1  debounced lane sensor, 1 while a car occupies the gate lane.
- conteo  in  4  current occupancy from the parking counter.
- hubo_error  in  1  error flag from the parking counter.
- gate_open  out  1  barrier open command.
- lane_dir  out  1  0 = entry, 1 = exit; valid while gate_open = 1.
- served_entry  out  1  one-cycle pulse when an entering car has fully passed.
- served_exit  out  1  one-cycle pulse when an exiting car has fully passed.
- denied  out  1  one-cycle pulse when a request is refused because the lot is full or empty.
- locked  out  1  controller is frozen by an error.

## Operation
- States: IDLE, WAIT_CAR, PASSING, CLOSING, LOCKED. Reset enters IDLE.
- Qualified requests:
  - ent_ok = entry_req & (conteo < CAPACITY)
  - ext_ok = exit_req & (conteo != 0)
- IDLE:
  - If exactly one request is qualified, serve it.
  - If both are qualified, serve the side not served last (round-robin). The last-served bit resets to "exit", so entry wins the first tie.
  - Serving: set lane_dir, load timer = 0, go to WAIT_CAR.
  - If a request is raised but not qualified and the other side is not qualified either, pulse denied. It re-pulses once every WAIT_CYCLES while the unqualified request persists; it does not pulse every cycle.
- WAIT_CAR:
  - If lane_busy = 1, go to PASSING.
  - Else, if timer reaches WAIT_CYCLES-1, go to IDLE without a served pulse (abandoned request).
- PASSING: on lane_busy falling to 0, pulse served_entry or served_exit according to lane_dir, load timer = 0, go to CLOSING.
- CLOSING:
  - Count to CLOSE_CYCLES-1, then go to IDLE and update the last-served bit.
  - If lane_busy rises during CLOSING, return to PASSING without a second served pulse until it falls again. That fall produces the pulse for the following car.
- gate_open = 1 in WAIT_CAR, PASSING and CLOSING; 0 in IDLE and LOCKED.
- hubo_error = 1 in any state forces LOCKED on the next edge. LOCKED holds gate_open = 0 and locked = 1, and is left only by reset.
- Requests arriving while the gate is not in IDLE are ignored, not queued. The side that is still requesting is arbitrated again on return to IDLE.
- The timer is 26 bits, saturating; it never wraps.

## Timing
- Reset values:
  - gate_open = 0
  - lane_dir = 0
  - served_entry = 0, served_exit = 0
  - denied = 0
  - locked = 0
  - timer = 0
  - last-served = exit
- All outputs are registered.
- Request to gate_open: a request sampled in IDLE at edge N gives gate_open = 1 after edge N+1 (1-cycle latency).
- A served pulse is high for exactly the cycle after the edge that sampled lane_busy = 0 in PASSING.
- gate_open falls exactly CLOSE_CYCLES cycles after the served pulse, provided lane_busy does not rise again.
- Reset mid-operation: next edge goes to IDLE with gate_open = 0, and no served pulse is emitted for the car that was in the lane.
- hubo_error and reset on the same edge: reset wins and the state is IDLE.

## Test plan
- Basic entry, with CAPACITY = 12, WAIT = 8, CLOSE = 4, conteo = 3:
  - Stimulus: entry_req = 1, lane_busy pulses high for 3 cycles.
  - Required: gate_open = 1 one cycle after the request, lane_dir = 0, served_entry pulses once, gate_open = 0 four cycles later.
- Full lot:
  - Stimulus: conteo = 12, entry_req held for 20 cycles.
  - Required: gate_open stays 0, denied pulses at cycle 1 and then every 8 cycles.
- Tie arbitration:
  - Stimulus: conteo = 5, entry_req = exit_req = 1 held.
  - Required: first service has lane_dir = 0, second has lane_dir = 1, third has lane_dir = 0.
- Timeout:
  - Stimulus: exit_req = 1 with conteo = 2, lane_busy never rises.
  - Required: gate_open is high for exactly 8 cycles, no served pulse, state returns to IDLE.
- Tailgate:
  - Stimulus: lane_busy rises again 2 cycles into CLOSING.
  - Required: gate stays open, a second served pulse on the second fall, and the close count restarts.
- Error and reset:
  - Stimulus: hubo_error = 1 during PASSING.
  - Required: locked = 1 and gate_open = 0 on the next cycle; requests are ignored; reset returns all outputs to 0.
